// File: rtl/daq_fmt_pkg.sv
// Shared types and constants for the AXI-Stream to DAQ-link event formatter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package daq_fmt_pkg;

  // Formatter FSM: wait for a packet, pack its payload, then close the fragment
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TRAILER = 2'd2
  } state_t;

  localparam logic [3:0] HDR_NIB = 4'h5;
  localparam logic [3:0] TRL_NIB = 4'hA;

  // Header fields: {nib, evt_type, lv1, bx, source_id, 8'h00}
  localparam int HDR_NIB_LSB = 60;
  localparam int HDR_EVT_LSB = 56;
  localparam int HDR_LV1_LSB = 32;
  localparam int HDR_BX_LSB  = 20;
  localparam int HDR_SRC_LSB = 8;

  // Trailer fields: {nib, 4'h0, len, crc, 8'h00, 7'h0, trunc}
  localparam int TRL_NIB_LSB   = 60;
  localparam int TRL_LEN_LSB   = 32;
  localparam int TRL_CRC_LSB   = 16;
  localparam int TRL_TRUNC_BIT = 0;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Bunch-crossing number is not tracked by this writer; the field is fixed at zero.
  localparam logic [11:0] HDR_BX = 12'h000;

  function automatic logic [63:0] make_header(input logic [3:0]  evt_type,
                                              input logic [23:0] lv1,
                                              input logic [11:0] source_id);
    logic [63:0] w;
    w = '0;
    w[HDR_NIB_LSB +: 4]  = HDR_NIB;
    w[HDR_EVT_LSB +: 4]  = evt_type;
    w[HDR_LV1_LSB +: 24] = lv1;
    w[HDR_BX_LSB  +: 12] = HDR_BX;
    w[HDR_SRC_LSB +: 12] = source_id;
    return w;
  endfunction

  function automatic logic [63:0] make_trailer(input logic [23:0] len,
                                               input logic [15:0] crc,
                                               input logic        trunc);
    logic [63:0] w;
    w = '0;
    w[TRL_NIB_LSB +: 4]  = TRL_NIB;
    w[TRL_LEN_LSB +: 24] = len;
    w[TRL_CRC_LSB +: 16] = crc;
    w[TRL_TRUNC_BIT]     = trunc;
    return w;
  endfunction

endpackage

// File: rtl/axis_to_daq_formatter_crc.sv
// CRC-16-CCITT over 64-bit event words, one whole word per clock, MSB first.
// Latency: crc reflects a word one cycle after start/upd qualifies it.
// Backpressure: none; follows the formatter's emit strobes. Built only with DAQ_FMT_CRC_EN.
`ifdef DAQ_FMT_CRC_EN
module daq_crc16_64
  import daq_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        upd,
  input  logic [63:0] word,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [63:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 63; i >= 0; i--) begin
      if (r[15] ^ w[i]) r = {r[14:0], 1'b0} ^ CRC_POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Header word restarts the checksum from the seed; payload words fold into the running value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (start) begin
      crc <= crc_step(CRC_INIT, word);
    end else if (upd) begin
      crc <= crc_step(crc, word);
    end
  end

endmodule
`endif

// File: rtl/axis_to_daq_formatter.sv
// Packs 32-bit AXI-Stream packets into header/payload/trailer 64-bit DAQ-link fragments.
// Latency: every daq_* word is registered, one cycle after the decision/beat that produces it.
// Backpressure: go = daq_ready & ~daq_almost_full gates header, beat accept and trailer; no per-word stall.
// Optional: DAQ_FMT_CRC_EN puts a CRC-16-CCITT of header+payload in trailer[31:16] (else 0).
module axis_to_daq_formatter #(
  parameter logic [11:0] SOURCE_ID   = 12'h000,
  parameter int          MAX_PAYLOAD = 1024,
  parameter logic [3:0]  EVT_TYPE    = 4'h1,
  // First LV1 id issued after reset
  parameter logic [23:0] LV1_INIT    = 24'h000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        daq_valid,
  output logic        daq_header,
  output logic        daq_trailer,
  output logic [63:0] daq_data,
  input  logic        daq_ready,
  input  logic        daq_almost_full,
  output logic [23:0] evt_count,
  output logic        overflow
);

  import daq_fmt_pkg::*;

  localparam int                CNT_W   = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_PAYLOAD);

  state_t           state;
  state_t           state_nxt;
  logic             go;
  logic             accept;
  logic             emit_hdr;
  logic             emit_pay;
  logic             emit_trl;
  logic             drop_beat;
  logic             pay_full;
  logic             odd_beat;
  logic             trunc;
  logic [31:0]      hold_lo;
  logic [23:0]      lv1;
  logic [23:0]      len;
  logic [CNT_W-1:0] pay_cnt;
  logic [15:0]      crc_val;
  logic [63:0]      hdr_word;
  logic [63:0]      pay_word;
  logic [63:0]      trl_word;
  logic [63:0]      word_nxt;

  assign go       = daq_ready & ~daq_almost_full;
  assign accept   = s_axis_tvalid & s_axis_tready;
  assign pay_full = (pay_cnt == MAX_CNT);

  // A payload word leaves on every odd beat, or on a lone even beat closing the packet,
  // unless the event already holds its maximum payload; such beats are consumed silently.
  assign emit_pay  = accept & (odd_beat | s_axis_tlast) & ~pay_full;
  assign drop_beat = accept & pay_full;

  // Length counts emitted words only, header and trailer included
  assign len = 24'(pay_cnt) + 24'd2;

  assign hdr_word = make_header(EVT_TYPE, lv1, SOURCE_ID);
  assign pay_word = odd_beat ? {s_axis_tdata, hold_lo} : {32'h0000_0000, s_axis_tdata};
  assign trl_word = make_trailer(len, crc_val, trunc);

`ifdef DAQ_FMT_CRC_EN
  daq_crc16_64 u_crc (
    .clk   (clk),
    .rst   (rst),
    .start (emit_hdr),
    .upd   (emit_pay),
    .word  (word_nxt),
    .crc   (crc_val)
  );
`else
  assign crc_val = 16'h0000;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, stream ready and header/trailer strobes
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    emit_hdr      = 1'b0;
    emit_trl      = 1'b0;
    case (state)
      ST_IDLE: begin
        // Header goes out on sight of a packet; its first beat is taken in PAYLOAD
        if (s_axis_tvalid && go) begin
          emit_hdr  = 1'b1;
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        s_axis_tready = go;
        if (s_axis_tvalid && go && s_axis_tlast) state_nxt = ST_TRAILER;
      end
      ST_TRAILER: begin
        if (go) begin
          emit_trl  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Select the word to be registered onto the link this cycle
  always_comb begin
    word_nxt = pay_word;
    if (emit_hdr)      word_nxt = hdr_word;
    else if (emit_trl) word_nxt = trl_word;
  end

  // Link output register; data holds its last value between words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      daq_valid   <= 1'b0;
      daq_header  <= 1'b0;
      daq_trailer <= 1'b0;
      daq_data    <= '0;
    end else begin
      daq_valid   <= emit_hdr | emit_pay | emit_trl;
      daq_header  <= emit_hdr;
      daq_trailer <= emit_trl;
      if (emit_hdr || emit_pay || emit_trl) daq_data <= word_nxt;
    end
  end

  // Per-event packing state: beat parity, held low half, payload count, truncation flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odd_beat <= 1'b0;
      hold_lo  <= '0;
      pay_cnt  <= '0;
      trunc    <= 1'b0;
      overflow <= 1'b0;
    end else if (emit_hdr) begin
      odd_beat <= 1'b0;
      pay_cnt  <= '0;
      trunc    <= 1'b0;
    end else if (accept) begin
      odd_beat <= ~odd_beat;
      if (!odd_beat) hold_lo <= s_axis_tdata;
      if (emit_pay)  pay_cnt <= pay_cnt + CNT_W'(1);
      if (drop_beat) begin
        trunc    <= 1'b1;
        overflow <= 1'b1;
      end
    end
  end

  // Event numbering: the trailer publishes the finished LV1 id and advances to the next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lv1       <= LV1_INIT;
      evt_count <= '0;
    end else if (emit_trl) begin
      evt_count <= lv1;
      lv1       <= lv1 + 24'd1;
    end
  end

endmodule
